branch_predict_unit: RTL
========================

// Module: branch_predict_unit
// PURPOSE
//  Fetch-stage predictor for the 5-stage MIPS pipeline: direct-mapped BTB, per-entry saturating counters, return-address stack.
//  IF looks up the current PC combinationally and redirects fetch on a predicted-taken hit.
//  EX/ID resolution updates the tables one cycle later; mispredict recovery (flush) stays in the core.
//  Replaces the fixed predict-not-taken/flush-always scheme.
// PARAMETERS
//  ENTRIES    16  BTB entries; power of 2, >=2; IDX_W = log2(ENTRIES)
//  CTR_W      2   saturating counter width; predict taken when counter MSB = 1
//  RAS_DEPTH  4   return-address stack entries; power of 2, >=1
//  ADDR_W     32  PC width; bit ADDR_W-1 is the kernel/supervisor bit and is part of the tag
// PORTS
//  clk          in   1       pipeline clock
//  reset        in   1       asynchronous, active-high
//  if_pc        in   ADDR_W  PC being fetched
//  pred_taken   out  1       redirect fetch to pred_target next cycle
//  pred_target  out  ADDR_W  predicted target; 0 when pred_taken=0
//  upd_valid    in   1       resolution strobe, one per resolved control instruction
//  upd_pc       in   ADDR_W  PC of the resolved instruction
//  upd_kind     in   2       0 cond branch, 1 direct jump (j), 2 call (jal/jalr), 3 return (jr $31)
//  upd_taken    in   1       actual direction; ignored for kinds 1-3 (always taken)
//  upd_target   in   ADDR_W  actual target
//  ras_flush    in   1       clears RAS (exception entry, ILLOP/XADR)
// BEHAVIOUR
//  Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]. Entry = {valid, tag, kind, ctr, target}.
//  Lookup: combinational, zero latency, reads registered state only; no write-to-read bypass.
//   If the same index is updated in the same cycle, lookup sees the pre-edge contents.
//  Hit = valid & tag match.
//   kind 0: pred_taken = ctr[CTR_W-1]; target = entry target.
//   kind 1/2: pred_taken = 1.
//   kind 3: pred_taken = (ras_count != 0); target = RAS top.
//  pred_target is forced to 0 whenever pred_taken = 0.
//  Update on posedge clk when upd_valid:
//   kind 0 miss, taken: allocate; ctr = 2^(CTR_W-1) (weak taken); target = upd_target.
//   kind 0 miss, not taken: no allocation, no state change.
//   kind 0 hit: ctr +1 if taken, -1 if not; saturate at 0 and 2^CTR_W-1.
//    Target is rewritten only when taken.
//   kind 1/2/3: allocate or overwrite; ctr = max; target = upd_target (unused for kind 3).
//   Allocation always evicts the indexed entry (direct-mapped, no replacement state).
//  RAS, committed at update time:
//   kind 2 pushes upd_pc+4; kind 3 pops.
//   Push when full: circular overwrite of the oldest entry; ras_count saturates at RAS_DEPTH.
//   Pop when empty: no-op; count stays 0.
//   ras_flush: count <= 0 and takes priority over a same-cycle push/pop.
//   The BTB update of that cycle still happens.
//  Reset, async, any cycle including mid-update:
//   all valid bits 0; ctrs 0; RAS count and pointer 0.
//   pred_taken = 0 and pred_target = 0 immediately, not waiting for a clock edge.
//   Target storage need not be reset.
//  Width rules:
//   upd_pc+4 wraps modulo 2^ADDR_W.
//   Counters are CTR_W bits, unsigned.
//   Tag carries the kernel bit, so user and kernel PCs never alias.
// STRUCTURE
//  Package bp_pkg: BP_KIND_{BR,J,CALL,RET} constants; CTR_MAX and CTR_WEAK_T as functions of CTR_W.
//  BTB arrays are flops, small enough for ENTRIES <= 64.
//  Sub-module bp_ras: RAS_DEPTH circular stack with push/pop/flush, top, count.
// TESTING
//  Reset, then if_pc=0x0040 -> pred_taken=0, pred_target=0.
//   Assert reset mid-run -> outputs 0 immediately.
//  Cond branch at 0x100, taken to 0x80 -> next lookup of 0x100: taken, 0x80.
//   Two not-taken updates -> not taken.
//   Four taken updates -> ctr=3; one not-taken -> still taken.
//  Not-taken miss at 0x200 -> no allocation.
//   0x240 (ENTRIES=16, same index as 0x200) keeps its prior entry.
//  jal at 0x300 to 0x1000, then jr $31 at 0x1010:
//   lookup 0x1010 -> taken, 0x304.
//   ras_flush, then lookup 0x1010 -> not taken.
//  Five nested calls (RAS_DEPTH=4), then five returns:
//   first four pops give the last four return addresses newest-first.
//   Fifth return: count 0, not taken.
//  Aliasing: user 0x0000_0100 and kernel 0x8000_0100 map to one index.
//   Updating one evicts the other; the kernel PC never hits on the user tag.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-kind codes and counter constants for the branch predictor.
package bp_pkg;
  localparam logic [1:0] BP_KIND_BR = 2'd0, BP_KIND_J = 2'd1, BP_KIND_CALL = 2'd2, BP_KIND_RET = 2'd3;
  function automatic int ctr_max(input int w);
    return (1 << w) - 1;
  endfunction
  function automatic int ctr_weak_t(input int w);
    return 1 << (w - 1);
  endfunction
endpackage

// File: rtl/bp_ras.sv
// bp_ras: circular return-address stack; a push when full overwrites the oldest entry.
module bp_ras #(
  parameter int DEPTH = 4,
  parameter int W = 32,
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count
);
  logic [W-1:0] stack [DEPTH];
  logic [PW-1:0] ptr, ptr_inc, ptr_dec;
  assign ptr_inc = ptr == PW'(DEPTH - 1) ? '0 : ptr + 1'b1;
  assign ptr_dec = ptr == '0 ? PW'(DEPTH - 1) : ptr - 1'b1;
  assign top = stack[ptr_dec];
  always_ff @(posedge clk or posedge reset)
    if (reset || flush) begin
      ptr <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr_inc;
      count <= count == CW'(DEPTH) ? count : count + 1'b1;
    end else if (pop && count != '0) begin
      ptr <= ptr_dec;
      count <= count - 1'b1;
    end
  always_ff @(posedge clk)
    if (push) stack[ptr] <= push_data;
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with saturating counters plus a return-address stack.
module branch_predict_unit
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CTR_W = 2,
  parameter int RAS_DEPTH = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [1:0]        upd_kind,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              ras_flush
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int RCW = $clog2(RAS_DEPTH + 1);
  localparam logic [CTR_W-1:0] CMAX = CTR_W'(ctr_max(CTR_W));
  localparam logic [CTR_W-1:0] CWEAK = CTR_W'(ctr_weak_t(CTR_W));
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0] tag [ENTRIES];
  logic [1:0] kind [ENTRIES];
  logic [CTR_W-1:0] ctr [ENTRIES];
  logic [ADDR_W-1:0] target [ENTRIES];
  logic [IDX_W-1:0] li, ui;
  logic lhit, uhit, wr_ent, wr_tgt;
  logic [CTR_W-1:0] ctr_nxt;
  logic [ADDR_W-1:0] ras_top;
  logic [RCW-1:0] ras_count;
  assign li = if_pc[IDX_W+1:2];
  assign ui = upd_pc[IDX_W+1:2];
  assign lhit = valid[li] && tag[li] == if_pc[ADDR_W-1:IDX_W+2];
  assign uhit = valid[ui] && tag[ui] == upd_pc[ADDR_W-1:IDX_W+2];
  // a not-taken branch that misses leaves the table untouched
  assign wr_ent = upd_valid && (upd_kind != BP_KIND_BR || upd_taken || uhit);
  assign wr_tgt = upd_valid && (upd_kind != BP_KIND_BR || upd_taken);
  always_comb begin
    pred_taken = lhit && (kind[li] == BP_KIND_BR ? ctr[li][CTR_W-1] :
                          kind[li] == BP_KIND_RET ? ras_count != '0 : 1'b1);
    pred_target = !pred_taken ? '0 : kind[li] == BP_KIND_RET ? ras_top : target[li];
    ctr_nxt = upd_kind != BP_KIND_BR ? CMAX :
              !uhit ? CWEAK :
              upd_taken ? (ctr[ui] == CMAX ? CMAX : ctr[ui] + 1'b1) :
              (ctr[ui] == '0 ? '0 : ctr[ui] - 1'b1);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= '0;
    end else if (wr_ent) begin
      valid[ui] <= 1'b1;
      ctr[ui] <= ctr_nxt;
    end
  always_ff @(posedge clk) begin
    if (wr_ent) begin
      tag[ui] <= upd_pc[ADDR_W-1:IDX_W+2];
      kind[ui] <= upd_kind;
    end
    if (wr_tgt) target[ui] <= upd_target;
  end
  bp_ras #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk(clk),
    .reset(reset),
    .push(upd_valid && upd_kind == BP_KIND_CALL),
    .pop(upd_valid && upd_kind == BP_KIND_RET),
    .flush(ras_flush),
    .push_data(upd_pc + ADDR_W'(4)),
    .top(ras_top),
    .count(ras_count)
  );
endmodule
